// File: rtl/pin_ctrl_pkg.sv
// pin_ctrl_pkg: register map shared by pin_ctrl and its clients
package pin_ctrl_pkg;
  localparam logic [1:0] ADDR_DIR = 2'd0;
  localparam logic [1:0] ADDR_OUT = 2'd1;
  localparam logic [1:0] ADDR_IN = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
endpackage

// File: rtl/pin_filter.sv
// pin_filter: two-flop synchroniser and stability filter for one pin, with a toggle pulse
module pin_filter #(
  parameter int FILTER_BITS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt,
  output logic toggle
);
  localparam logic [FILTER_BITS-1:0] LAST = FILTER_BITS'(2 ** FILTER_BITS - 2);
  logic s1, s2;
  logic [FILTER_BITS-1:0] cnt;
  always_comb toggle = (s2 != filt) && (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      filt <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      filt <= toggle ? s2 : filt;
      cnt <= (s2 != filt && !toggle) ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/pin_ctrl.sv
// pin_ctrl: pin direction/output registers, filtered inputs and sticky edge flags behind a request port
module pin_ctrl
  import pin_ctrl_pkg::*;
#(
  parameter int IO_PINS = 16,
  parameter int FILTER_BITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_PINS-1:0] pin_data_in,
  output logic [IO_PINS-1:0] pin_dir,
  output logic [IO_PINS-1:0] pin_data_out,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_addr,
  input  logic [IO_PINS-1:0] req_wdata,
  output logic               resp_valid,
  output logic [IO_PINS-1:0] resp_rdata,
  output logic               irq
);
  logic [IO_PINS-1:0] filt, toggle, edge_q, rd_val, clr;
  logic accept;
  genvar i;
  for (i = 0; i < IO_PINS; i++) begin : g_pin
    pin_filter #(.FILTER_BITS(FILTER_BITS)) u_filter (
      .clk(clk),
      .rst(rst),
      .din(pin_data_in[i]),
      .filt(filt[i]),
      .toggle(toggle[i])
    );
  end
  always_comb begin
    req_ready = ~rst;
    accept = req_valid & ~rst;
    irq = |edge_q;
    rd_val = req_addr == ADDR_DIR ? pin_dir :
             req_addr == ADDR_OUT ? pin_data_out :
             req_addr == ADDR_IN  ? filt : edge_q;
    clr = !accept || req_addr != ADDR_EDGE ? '0 : req_we ? req_wdata : edge_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_dir <= '0;
      pin_data_out <= '0;
      edge_q <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      pin_dir <= accept && req_we && req_addr == ADDR_DIR ? req_wdata : pin_dir;
      pin_data_out <= accept && req_we && req_addr == ADDR_OUT ? req_wdata : pin_data_out;
      edge_q <= (edge_q & ~clr) | toggle;
      resp_valid <= accept;
      resp_rdata <= accept && !req_we ? rd_val : '0;
    end
  end
endmodule

// File: tb/tb_pin_ctrl.sv
// tb_pin_ctrl: directed and randomized checks of pin_ctrl against a sample-history reference model
module tb_pin_ctrl;
  localparam int P = 16;
  localparam int FB = 3;
  localparam int N = (1 << FB) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [P-1:0] pin_data_in = '0;
  logic [P-1:0] pin_dir, pin_data_out, resp_rdata;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [P-1:0] req_wdata = '0;
  logic req_ready, resp_valid, irq;
  int checks = 0;
  int errors = 0;
  logic [P-1:0] m_dir, m_out, m_filt, m_edge, m_rd;
  logic m_rv;
  logic [P-1:0] hist[$];
  always #5 clk = ~clk;
  pin_ctrl #(.IO_PINS(P), .FILTER_BITS(FB)) dut (
    .clk(clk),
    .rst(rst),
    .pin_data_in(pin_data_in),
    .pin_dir(pin_dir),
    .pin_data_out(pin_data_out),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .irq(irq)
  );
  task automatic model_reset();
    m_dir = '0;
    m_out = '0;
    m_filt = '0;
    m_edge = '0;
    m_rd = '0;
    m_rv = 1'b0;
    hist.delete();
    for (int j = 0; j < N + 2; j++) hist.push_back('0);
  endtask
  task automatic step();
    logic [P-1:0] tog, rd, clr;
    logic acc;
    @(posedge clk);
    acc = req_valid && !rst;
    rd = req_addr == 2'd0 ? m_dir : req_addr == 2'd1 ? m_out : req_addr == 2'd2 ? m_filt : m_edge;
    clr = (acc && req_addr == 2'd3) ? (req_we ? req_wdata : m_edge) : '0;
    hist.push_back(pin_data_in);
    void'(hist.pop_front());
    tog = '1;
    for (int j = 2; j <= N + 1; j++) tog &= hist[N + 1 - j] ^ m_filt;
    if (rst) model_reset();
    else begin
      if (acc && req_we && req_addr == 2'd0) m_dir = req_wdata;
      if (acc && req_we && req_addr == 2'd1) m_out = req_wdata;
      m_edge = (m_edge & ~clr) | tog;
      m_filt = m_filt ^ tog;
      m_rv = acc;
      m_rd = (acc && !req_we) ? rd : '0;
    end
    @(negedge clk);
  endtask
  task automatic drive(input logic v, input logic we, input logic [1:0] a, input logic [P-1:0] d);
    req_valid = v;
    req_we = we;
    req_addr = a;
    req_wdata = d;
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'd2, '0);
    step();
    step();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    checks++;
    if ({pin_dir, pin_data_out, resp_rdata, resp_valid, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outs got dir=%h out=%h rd=%h rv=%b irq=%b exp all 0", pin_dir, pin_data_out, resp_rdata, resp_valid, irq);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after got %b exp 1", req_ready); end
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL read_in_reset got rv=%b rd=%h exp rv=1 rd=0000", resp_valid, resp_rdata);
    end
  endtask
  task automatic test_regs();
    drive(1'b1, 1'b1, 2'd0, 16'hFF00);
    step();
    checks++;
    if (pin_dir !== 16'hFF00 || resp_valid !== 1'b1 || resp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL wr_dir got dir=%h rv=%b rd=%h exp FF00 1 0000", pin_dir, resp_valid, resp_rdata);
    end
    drive(1'b1, 1'b1, 2'd1, 16'hCCCC);
    step();
    checks++;
    if (pin_data_out !== 16'hCCCC || resp_valid !== 1'b1 || pin_dir !== 16'hFF00) begin
      errors++;
      $display("FAIL wr_out got out=%h rv=%b dir=%h exp CCCC 1 FF00", pin_data_out, resp_valid, pin_dir);
    end
    drive(1'b1, 1'b0, 2'd0, '0);
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 16'hFF00) begin
      errors++;
      $display("FAIL rd_dir got rv=%b rd=%h exp 1 FF00", resp_valid, resp_rdata);
    end
    drive(1'b1, 1'b0, 2'd1, '0);
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 16'hCCCC) begin
      errors++;
      $display("FAIL rd_out got rv=%b rd=%h exp 1 CCCC", resp_valid, resp_rdata);
    end
    drive(1'b0, 1'b0, 2'd0, '0);
    step();
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_rv got %b exp 0", resp_valid); end
  endtask
  task automatic test_filter();
    pin_data_in[0] = 1'b1;
    steps(8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL filt_early got irq=%b exp 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL filt_9 got irq=%b exp 1", irq); end
    drive(1'b1, 1'b0, 2'd2, '0);
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    checks++;
    if (resp_rdata !== 16'h0001) begin errors++; $display("FAIL rd_in0 got %h exp 0001", resp_rdata); end
  endtask
  task automatic test_glitch();
    pin_data_in[1] = 1'b1;
    steps(5);
    pin_data_in[1] = 1'b0;
    steps(20);
    drive(1'b1, 1'b0, 2'd2, '0);
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    checks++;
    if (resp_rdata !== 16'h0001 || irq !== 1'b1) begin
      errors++;
      $display("FAIL glitch got in=%h irq=%b exp 0001 1", resp_rdata, irq);
    end
  endtask
  task automatic test_edge_race();
    pin_data_in[0] = 1'b0;
    steps(8);
    drive(1'b1, 1'b0, 2'd3, '0);
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    checks++;
    if (resp_rdata !== 16'h0001 || irq !== 1'b1) begin
      errors++;
      $display("FAIL race got rd=%h irq=%b exp 0001 1", resp_rdata, irq);
    end
    drive(1'b1, 1'b1, 2'd3, 16'h0001);
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c got irq=%b exp 0", irq); end
    drive(1'b1, 1'b0, 2'd3, '0);
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    checks++;
    if (resp_rdata !== 16'h0000) begin errors++; $display("FAIL edge_clr got %h exp 0000", resp_rdata); end
  endtask
  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 2'd0, 16'h00FF);
    step();
    drive(1'b1, 1'b1, 2'd1, 16'h1234);
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    pin_data_in[0] = 1'b1;
    steps(12);
    pin_data_in[0] = 1'b0;
    steps(4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst irq got %b exp 1", irq); end
    drive(1'b1, 1'b0, 2'd1, '0);
    step();
    drive(1'b0, 1'b0, 2'd0, '0);
    rst = 1'b1;
    step();
    checks++;
    if ({resp_valid, resp_rdata, pin_dir, pin_data_out, irq} !== '0) begin
      errors++;
      $display("FAIL mid_rst got rv=%b rd=%h dir=%h out=%h irq=%b exp all 0", resp_valid, resp_rdata, pin_dir, pin_data_out, irq);
    end
    rst = 1'b0;
    pin_data_in[0] = 1'b1;
    steps(8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL restart_early got irq=%b exp 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL restart_9 got irq=%b exp 1", irq); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), P'($urandom));
      pin_data_in = pin_data_in ^ P'($urandom & $urandom & $urandom & $urandom);
      #1;
      checks++;
      if (req_ready !== !rst) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, req_ready, !rst); end
      step();
      checks++;
      if (pin_dir !== m_dir || pin_data_out !== m_out) begin
        errors++;
        $display("FAIL rnd_regs cyc %0d got %h/%h exp %h/%h", c, pin_dir, pin_data_out, m_dir, m_out);
      end
      checks++;
      if (resp_valid !== m_rv || resp_rdata !== m_rd) begin
        errors++;
        $display("FAIL rnd_resp cyc %0d got %b/%h exp %b/%h", c, resp_valid, resp_rdata, m_rv, m_rd);
      end
      checks++;
      if (irq !== (|m_edge)) begin errors++; $display("FAIL rnd_irq cyc %0d got %b exp %b", c, irq, |m_edge); end
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, '0);
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_regs();
    test_filter();
    test_glitch();
    test_edge_race();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
